// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module  : regfile_write_arbiter
// Brief   : Round-robin arbiter for the register-file write port, with a
//           one-entry write stage and read-data forwarding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
  parameter int Addr_width = 4,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [Addr_width-1:0] req0_addr,
  input  logic [data_width-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [Addr_width-1:0] req1_addr,
  input  logic [data_width-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  hold,
  input  logic [Addr_width-1:0] rd_addr_1,
  input  logic [Addr_width-1:0] rd_addr_2,
  output logic [data_width-1:0] rd_data_1,
  output logic [data_width-1:0] rd_data_2,
  output logic                  we,
  output logic [Addr_width-1:0] addr_w,
  output logic [data_width-1:0] data_w,
  output logic [Addr_width-1:0] addr_r_1,
  output logic [Addr_width-1:0] addr_r_2,
  input  logic [data_width-1:0] data_r_1,
  input  logic [data_width-1:0] data_r_2,
  output logic [15:0]           wr_count
);

  logic                  r_stg_valid;
  logic [Addr_width-1:0] r_stg_addr;
  logic [data_width-1:0] r_stg_data;
  logic                  r_ptr;
  logic [15:0]           r_wr_count;

  logic w_we;
  logic w_free;
  logic w_grant0;
  logic w_grant1;
  logic w_accept;

  assign w_we   = r_stg_valid & ~hold;
  // The stage can take a new entry in the same cycle its current one commits.
  assign w_free = ~r_stg_valid | w_we;

  assign w_grant0 = req0_valid & (~req1_valid | ~r_ptr);
  assign w_grant1 = req1_valid & (~req0_valid |  r_ptr);

  assign req0_ready = w_grant0 & w_free;
  assign req1_ready = w_grant1 & w_free;
  assign w_accept   = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_valid <= 1'b0;
      r_stg_addr  <= '0;
      r_stg_data  <= '0;
      r_ptr       <= 1'b0;
      r_wr_count  <= 16'd0;
    end else begin
      if (w_accept) begin
        r_stg_valid <= 1'b1;
        r_stg_addr  <= req1_ready ? req1_addr : req0_addr;
        r_stg_data  <= req1_ready ? req1_data : req0_data;
        r_ptr       <= ~req1_ready;
      end else if (w_we) begin
        r_stg_valid <= 1'b0;
      end
      if (w_we) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  assign we       = w_we;
  assign addr_w   = r_stg_addr;
  assign data_w   = r_stg_data;
  assign wr_count = r_wr_count;

  assign addr_r_1 = rd_addr_1;
  assign addr_r_2 = rd_addr_2;

  // Forwarding stays active under hold so readers never see stale memory.
  assign rd_data_1 = (r_stg_valid && (r_stg_addr == rd_addr_1)) ? r_stg_data : data_r_1;
  assign rd_data_2 = (r_stg_valid && (r_stg_addr == rd_addr_2)) ? r_stg_data : data_r_2;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module  : tb_regfile_write_arbiter
// Brief   : Directed self-checking bench for regfile_write_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       hold;
  logic [3:0] rd_addr_1, rd_addr_2, addr_w, addr_r_1, addr_r_2;
  logic [7:0] rd_data_1, rd_data_2, data_w, data_r_1, data_r_2;
  logic       we;
  logic [15:0] wr_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [16] = '{default: 8'h00};

  always #5 clk = ~clk;

  always @(posedge clk) if (we) mem[addr_w] <= data_w;
  assign data_r_1 = mem[addr_r_1];
  assign data_r_2 = mem[addr_r_2];

  regfile_write_arbiter #(.Addr_width(4), .data_width(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .hold(hold), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .we(we), .addr_w(addr_w), .data_w(data_w),
    .addr_r_1(addr_r_1), .addr_r_2(addr_r_2),
    .data_r_1(data_r_1), .data_r_2(data_r_2),
    .wr_count(wr_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge so inputs change away from it.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    rd_addr_1 = '0; rd_addr_2 = '0;
    #2;
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_cnt", {16'd0, wr_count}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_rdy0", {31'd0, req0_ready}, 32'd1);
    check("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;

    // Single write with forwarding then readback
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 8'hA5; rd_addr_1 = 4'd3;
    #1;
    check("s_rdy0", {31'd0, req0_ready}, 32'd1);
    tick;
    req0_valid = 1'b0;
    #1;
    check("s_we", {31'd0, we}, 32'd1);
    check("s_addr_w", {28'd0, addr_w}, 32'd3);
    check("s_data_w", {24'd0, data_w}, 32'hA5);
    check("s_fwd", {24'd0, rd_data_1}, 32'hA5);
    tick;
    #1;
    check("s_we_off", {31'd0, we}, 32'd0);
    check("s_mem", {24'd0, rd_data_1}, 32'hA5);
    check("s_cnt", {16'd0, wr_count}, 32'd1);

    // Contention from reset: grants alternate 0,1,0,1
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 8'h22;
    #1;
    check("c0_rdy0", {31'd0, req0_ready}, 32'd1);
    check("c0_rdy1", {31'd0, req1_ready}, 32'd0);
    tick;
    req0_data = 8'h12;
    #1;
    check("c1_rdy0", {31'd0, req0_ready}, 32'd0);
    check("c1_rdy1", {31'd0, req1_ready}, 32'd1);
    check("c1_data_w", {24'd0, data_w}, 32'h11);
    check("c1_addr_w", {28'd0, addr_w}, 32'd1);
    tick;
    req1_data = 8'h23; rd_addr_2 = 4'd1;
    #1;
    check("c2_rdy0", {31'd0, req0_ready}, 32'd1);
    check("c2_rdy1", {31'd0, req1_ready}, 32'd0);
    check("c2_data_w", {24'd0, data_w}, 32'h22);
    check("c2_mem1", {24'd0, rd_data_2}, 32'h11);
    tick;
    req0_valid = 1'b0;
    #1;
    check("c3_rdy1", {31'd0, req1_ready}, 32'd1);
    check("c3_data_w", {24'd0, data_w}, 32'h12);
    tick;
    req1_valid = 1'b0;
    #1;
    check("c4_data_w", {24'd0, data_w}, 32'h23);
    tick;
    rd_addr_1 = 4'd1; rd_addr_2 = 4'd2;
    #1;
    check("c5_we", {31'd0, we}, 32'd0);
    check("c5_cnt", {16'd0, wr_count}, 32'd4);
    check("c5_mem1", {24'd0, rd_data_1}, 32'h12);
    check("c5_mem2", {24'd0, rd_data_2}, 32'h23);

    // Same address: ptr is 0, so 0x01 commits before 0x02
    req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 8'h01;
    req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 8'h02;
    #1;
    check("a_rdy0", {31'd0, req0_ready}, 32'd1);
    tick;
    req0_valid = 1'b0;
    #1;
    check("a_rdy1", {31'd0, req1_ready}, 32'd1);
    check("a_first", {24'd0, data_w}, 32'h01);
    tick;
    req1_valid = 1'b0; rd_addr_1 = 4'd5;
    #1;
    check("a_second", {24'd0, data_w}, 32'h02);
    check("a_fwd", {24'd0, rd_data_1}, 32'h02);
    tick;
    #1;
    check("a_mem", {24'd0, rd_data_1}, 32'h02);
    check("a_cnt", {16'd0, wr_count}, 32'd6);

    // Hold freezes the stage while forwarding continues
    req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 8'h7E;
    tick;
    req0_valid = 1'b0; hold = 1'b1;
    req1_valid = 1'b1; req1_addr = 4'd8; req1_data = 8'h88; rd_addr_2 = 4'd7;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("h_we", {31'd0, we}, 32'd0);
      check("h_rdy1", {31'd0, req1_ready}, 32'd0);
      check("h_fwd", {24'd0, rd_data_2}, 32'h7E);
      tick;
    end
    hold = 1'b0;
    #1;
    check("h_rel_we", {31'd0, we}, 32'd1);
    check("h_rel_rdy1", {31'd0, req1_ready}, 32'd1);
    tick;
    req1_valid = 1'b0;
    #1;
    check("h_mem7", {24'd0, rd_data_2}, 32'h7E);
    check("h_next_addr", {28'd0, addr_w}, 32'd8);
    check("h_next_data", {24'd0, data_w}, 32'h88);
    tick;
    #1;
    check("h_cnt", {16'd0, wr_count}, 32'd8);

    // Async reset discards a staged write
    req0_valid = 1'b1; req0_addr = 4'd4; req0_data = 8'h44;
    tick;
    req0_valid = 1'b0;
    #1;
    check("r_we_pre", {31'd0, we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("r_we_drop", {31'd0, we}, 32'd0);
    check("r_cnt", {16'd0, wr_count}, 32'd0);
    tick;
    rst_n = 1'b1; rd_addr_1 = 4'd4;
    #1;
    check("r_mem4", {24'd0, rd_data_1}, 32'h00);

    // Counter wrap after 65536 commits
    req0_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      req0_addr = i[3:0]; req0_data = i[7:0];
      #1;
      if (i == 0 || i == 65535) check("w_rdy0", {31'd0, req0_ready}, 32'd1);
      tick;
    end
    req0_valid = 1'b0;
    #1;
    check("w_cnt_max", {16'd0, wr_count}, 32'hFFFF);
    tick;
    #1;
    check("w_cnt_wrap", {16'd0, wr_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
